alu32_arbiter: RTL and testbench
================================

# alu32_arbiter

Sequencing front-end that shares one combinational `ALU32FF` between two requesters. It arbitrates round-robin between two valid/ready request ports and drives the ALU's one-hot `ctl`/`op1`/`op2` from registers. It holds those operands stable for a per-operation multicycle window: longer for MUL/MULH and DIV/REM. It then captures `res` into a registered response port with requester ID and an illegal-control error flag.

## Interface
- `MUL_CYCLES`, default 2: cycles the ALU inputs are held for `ALU_CTL_MUL`/`ALU_CTL_MULH`; legal range 1..15.
- `DIV_CYCLES`, default 4: cycles held for `ALU_CTL_DIV`/`ALU_CTL_REM`; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_vld` in 1: requester 0 has an operation.
- `req0_rdy` out 1: requester 0 accepted this cycle.
- `req0_ctl` in 16: one-hot ALU control, `ALU1HotCtl.v` encoding.
- `req0_op1`, `req0_op2` in 32 each: operands.
- `req1_vld`, `req1_rdy`, `req1_ctl`, `req1_op1`, `req1_op2`: same as requester 0.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_res` out 32: captured ALU result.
- `rsp_err` out 1: request `ctl` was not exactly one-hot.
- `alu_ctl` out 16, `alu_op1` out 32, `alu_op2` out 32: drive the ALU.
- `alu_res` in 32: ALU result.

## Operation
- FSM has three states: IDLE, EXEC, RESP. At reset the state is IDLE.
- Reset values:
  - `rsp_vld`, `rsp_id`, `rsp_res`, `rsp_err` are 0.
  - `alu_ctl`, `alu_op1`, `alu_op2` are 0.
  - Round-robin pointer favours requester 0.
  - Cycle counter is 0.
- IDLE, grant rules:
  - If only one `reqN_vld` is high, grant that requester.
  - If both are high, grant the requester not granted last. The pointer updates only on acceptance.
- `reqN_rdy` is combinational. It is 1 only in IDLE, for the granted requester. At most one `rdy` is high per cycle; both are 0 outside IDLE.
- On acceptance, latch `ctl`, `op1`, `op2` and the ID.
  - `ctl` exactly one-hot: go to EXEC with counter = L-1.
  - `ctl` zero or multi-hot: go to RESP with `rsp_err`=1, `rsp_res`=0. The ALU is not driven.
- Latency L:
  - `MUL_CYCLES` for MUL/MULH.
  - `DIV_CYCLES` for DIV/REM.
  - 1 for every other legal op (ADD, SUB, SLT, SLTU, SLL, SRL, SRA, AND, OR, XOR, NOT).
  - Unknown single one-hot bits use L=1 and are passed through unchecked.
- EXEC:
  - `alu_*` are driven from the latched registers and stay stable for all L cycles.
  - Counter decrements each cycle.
  - At counter==0: capture `alu_res` into `rsp_res`, set `rsp_err`=0, go to RESP.
- RESP:
  - `rsp_vld`=1; `rsp_id`, `rsp_res`, `rsp_err` are held stable.
  - When `rsp_rdy`=1, clear `rsp_vld` and go to IDLE.
- In IDLE and RESP, `alu_ctl`=0. `alu_op1`/`alu_op2` keep their last values.
- Requester inputs are ignored outside the acceptance cycle. Operands change freely after the handshake.
- The block does no arithmetic; `ALU32FF` semantics apply unchanged. For NOT, `op2` is forwarded but unused.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values. The in-flight operation is dropped and no response is produced.

## Timing
- Handshake in cycle N → `alu_ctl` valid in cycles N+1 .. N+L → `rsp_vld` high from cycle N+L+1.
- Minimum occupancy is L+2 cycles per op. Acceptance is impossible in the same cycle as the `rsp_rdy` handshake.
- Illegal ctl: handshake in cycle N → `rsp_vld` high in cycle N+1.
- `rsp_rdy` low holds RESP indefinitely; no request is accepted meanwhile.
- `alu_res` is sampled only on the final EXEC cycle's rising edge.

## Test plan
- ADD, requester 0: op1=0x0097423B, op2=0x014872C1 → `rsp_vld` 2 cycles after handshake, `rsp_res`=0x01DFB4FC, `rsp_id`=0, `rsp_err`=0.
- DIV with `DIV_CYCLES`=4: op1=0x0AE02023, op2=0x80000A12 → `alu_ctl` stable for 4 cycles, `rsp_vld` 5 cycles after handshake, `rsp_res`=0.
- Both requesters hold `vld` continuously with ADD 1+1 (req0) and SUB 5-3 (req1), `rsp_rdy`=1 → responses alternate id 0,1,0,1 with results 2,2,2,2. First grant goes to req0.
- `req1_ctl`=0x0003 (multi-hot) → `rsp_err`=1 and `rsp_res`=0 one cycle after handshake; `alu_ctl` stays 0 throughout.
- Backpressure: `rsp_rdy`=0 for 10 cycles after a MUL result → `rsp_vld`/`rsp_res` held, both `reqN_rdy`=0; IDLE is reached the cycle after `rsp_rdy` rises.
- `rst_n` pulsed low during EXEC of a MULH → all outputs 0 immediately, no response; the next request after reset is granted to req0.

Source files
------------

// File: rtl/alu32_arbiter.sv
// Round-robin front-end sharing one combinational ALU32FF between two requesters.
// Holds one-hot ALU operands for a per-op multicycle window and registers the result.
module alu32_arbiter #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_vld,
    output logic        req0_rdy,
    input  logic [15:0] req0_ctl,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_vld,
    output logic        req1_rdy,
    input  logic [15:0] req1_ctl,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic        rsp_id,
    output logic [31:0] rsp_res,
    output logic        rsp_err,
    output logic [15:0] alu_ctl,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_res
);

    localparam int DATA_W = 32;
    localparam int CTL_W  = 16;

    // One-hot control bit positions of the ALU1HotCtl encoding that need long latency
    localparam int BIT_MUL  = 11;
    localparam int BIT_MULH = 12;
    localparam int BIT_DIV  = 13;
    localparam int BIT_REM  = 14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_onehot(input logic [CTL_W-1:0] c);
        return (c != '0) && ((c & (c - 16'd1)) == '0);
    endfunction

    // Counter start value is L-1 so that counter==0 marks the final EXEC cycle
    function automatic logic [3:0] exec_count(input logic [CTL_W-1:0] c);
        if (c[BIT_MUL] || c[BIT_MULH])
            return 4'(MUL_CYCLES - 1);
        else if (c[BIT_DIV] || c[BIT_REM])
            return 4'(DIV_CYCLES - 1);
        else
            return 4'd0;
    endfunction

    logic [1:0]        state;
    logic              prio;
    logic [3:0]        cnt;

    logic              gnt_id;
    logic              accept;
    logic [CTL_W-1:0]  sel_ctl;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;

    // prio names the requester that wins when both are valid
    assign gnt_id  = (req0_vld && req1_vld) ? prio : req1_vld;
    assign accept  = (state == ST_IDLE) && (req0_vld || req1_vld);
    assign req0_rdy = accept && !gnt_id;
    assign req1_rdy = accept && gnt_id;

    assign sel_ctl = gnt_id ? req1_ctl : req0_ctl;
    assign sel_op1 = gnt_id ? req1_op1 : req0_op1;
    assign sel_op2 = gnt_id ? req1_op2 : req0_op2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            prio    <= 1'b0;
            cnt     <= 4'd0;
            rsp_vld <= 1'b0;
            rsp_id  <= 1'b0;
            rsp_res <= '0;
            rsp_err <= 1'b0;
            alu_ctl <= '0;
            alu_op1 <= '0;
            alu_op2 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        prio   <= ~gnt_id;
                        rsp_id <= gnt_id;
                        if (is_onehot(sel_ctl)) begin
                            alu_ctl <= sel_ctl;
                            alu_op1 <= sel_op1;
                            alu_op2 <= sel_op2;
                            cnt     <= exec_count(sel_ctl);
                            state   <= ST_EXEC;
                        end else begin
                            // Malformed control never reaches the ALU
                            rsp_err <= 1'b1;
                            rsp_res <= '0;
                            rsp_vld <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_res <= alu_res;
                        rsp_err <= 1'b0;
                        rsp_vld <= 1'b1;
                        alu_ctl <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_vld <= 1'b0;
                    alu_ctl <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter with a behavioural ALU32FF attached to the alu_* port.
module tb_alu32_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [15:0] req0_ctl, req1_ctl;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp_vld, rsp_rdy, rsp_id, rsp_err;
    logic [31:0] rsp_res;
    logic [15:0] alu_ctl;
    logic [31:0] alu_op1, alu_op2, alu_res;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu32_arbiter #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_ctl(req0_ctl),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_ctl(req1_ctl),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res)
    );

    // Behavioural ALU32FF; bit 15 stands in for an unknown op returning a marker value
    logic signed [63:0] prod_s;
    assign prod_s = $signed({{32{alu_op1[31]}}, alu_op1}) * $signed({{32{alu_op2[31]}}, alu_op2});

    always_comb begin
        alu_res = 32'h0;
        case (alu_ctl)
            16'h0001: alu_res = alu_op1 + alu_op2;
            16'h0002: alu_res = alu_op1 - alu_op2;
            16'h0004: alu_res = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            16'h0008: alu_res = {31'b0, alu_op1 < alu_op2};
            16'h0010: alu_res = alu_op1 << alu_op2[4:0];
            16'h0020: alu_res = alu_op1 >> alu_op2[4:0];
            16'h0040: alu_res = $signed(alu_op1) >>> alu_op2[4:0];
            16'h0080: alu_res = alu_op1 & alu_op2;
            16'h0100: alu_res = alu_op1 | alu_op2;
            16'h0200: alu_res = alu_op1 ^ alu_op2;
            16'h0400: alu_res = ~alu_op1;
            16'h0800: alu_res = prod_s[31:0];
            16'h1000: alu_res = prod_s[63:32];
            16'h2000: alu_res = (alu_op2 == 0) ? 32'hFFFF_FFFF : 32'($signed(alu_op1) / $signed(alu_op2));
            16'h4000: alu_res = (alu_op2 == 0) ? alu_op1 : 32'($signed(alu_op1) % $signed(alu_op2));
            16'h8000: alu_res = 32'hDEAD_BEEF;
            default:  alu_res = 32'h0;
        endcase
    end

    typedef struct {
        logic        id;
        logic [15:0] ctl;
        logic [31:0] op1;
        logic [31:0] op2;
        int          lat;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int limit, output int cyc);
        cyc = 1;
        while (!rsp_vld && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        int n;
        logic rdy;
        logic legal;
        string tag;
        legal = (v.lat != 0);
        tag = $sformatf("vec%0d", idx);
        rsp_rdy = 1'b0;
        if (v.id) begin
            req1_vld = 1'b1; req1_ctl = v.ctl; req1_op1 = v.op1; req1_op2 = v.op2;
        end else begin
            req0_vld = 1'b1; req0_ctl = v.ctl; req0_op1 = v.op1; req0_op2 = v.op2;
        end
        #1;
        n = 0;
        rdy = v.id ? req1_rdy : req0_rdy;
        while (!rdy && n < 10) begin
            tick();
            n++;
            rdy = v.id ? req1_rdy : req0_rdy;
        end
        chk({tag, "_grant"}, {31'b0, rdy}, 32'd1);
        chk({tag, "_other_rdy"}, {31'b0, v.id ? req0_rdy : req1_rdy}, 32'd0);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        // Walk EXEC: operands must be held steady for the whole window
        n = 1;
        while (!rsp_vld && n < 40) begin
            chk({tag, "_alu_ctl"}, {16'b0, alu_ctl}, {16'b0, legal ? v.ctl : 16'h0});
            chk({tag, "_alu_op1"}, alu_op1, v.op1);
            chk({tag, "_alu_op2"}, alu_op2, v.op2);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, v.lat + 1);
        chk({tag, "_res"}, rsp_res, v.res);
        chk({tag, "_id"}, {31'b0, rsp_id}, {31'b0, v.id});
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, v.err});
        chk({tag, "_resp_alu_ctl"}, {16'b0, alu_ctl}, 32'd0);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk({tag, "_vld_clear"}, {31'b0, rsp_vld}, 32'd0);
    endtask

    initial begin
        int cyc;
        int got;
        logic [1:0] both;
        logic exp_id;

        vecs[0]  = '{1'b0, 16'h0001, 32'h0097_423B, 32'h0148_72C1, 1, 32'h01DF_B4FC, 1'b0};
        vecs[1]  = '{1'b0, 16'h2000, 32'h0AE0_2023, 32'h8000_0A12, 4, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 16'h0002, 32'd10,        32'd3,         1, 32'd7,         1'b0};
        vecs[3]  = '{1'b1, 16'h0080, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'h00F0_000F, 1'b0};
        vecs[4]  = '{1'b0, 16'h0200, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555, 1'b0};
        vecs[5]  = '{1'b0, 16'h0400, 32'h1234_5678, 32'h0000_0000, 1, 32'hEDCB_A987, 1'b0};
        vecs[6]  = '{1'b1, 16'h0800, 32'd7,         32'd6,         2, 32'd42,        1'b0};
        vecs[7]  = '{1'b0, 16'h1000, 32'h0001_0000, 32'h0001_0000, 2, 32'h0000_0001, 1'b0};
        vecs[8]  = '{1'b1, 16'h4000, 32'd17,        32'd5,         4, 32'd2,         1'b0};
        vecs[9]  = '{1'b1, 16'h0003, 32'h1111_1111, 32'h2222_2222, 0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 32'h3333_3333, 32'h4444_4444, 0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 16'h8000, 32'h0000_0005, 32'h0000_0006, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1'b1, 16'h0010, 32'h0000_0001, 32'd31,        1, 32'h8000_0000, 1'b0};

        rst_n = 1'b0; rsp_rdy = 1'b0;
        req0_vld = 1'b0; req0_ctl = '0; req0_op1 = '0; req0_op2 = '0;
        req1_vld = 1'b0; req1_ctl = '0; req1_op1 = '0; req1_op2 = '0;
        #1;
        chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        chk("rst_rsp_id_err", {30'b0, rsp_id, rsp_err}, 32'd0);
        chk("rst_alu_ctl", {16'b0, alu_ctl}, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Both requesters held valid: grants must alternate starting with req0
        req0_vld = 1'b1; req0_ctl = 16'h0001; req0_op1 = 32'd1; req0_op2 = 32'd1;
        req1_vld = 1'b1; req1_ctl = 16'h0002; req1_op1 = 32'd5; req1_op2 = 32'd3;
        rsp_rdy = 1'b1;
        #1;
        got = 0;
        exp_id = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            both = {req1_rdy, req0_rdy};
            chk("rr_single_rdy", {31'b0, both == 2'b11}, 32'd0);
            if (rsp_vld) begin
                chk($sformatf("rr_id%0d", got), {31'b0, rsp_id}, {31'b0, exp_id});
                chk($sformatf("rr_res%0d", got), rsp_res, 32'd2);
                exp_id = ~exp_id;
                got++;
            end
            if (got < 4) tick();
        end
        chk("rr_count", got, 4);
        req0_vld = 1'b0; req1_vld = 1'b0;
        tick();
        rsp_rdy = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) do_vec(vecs[i], i);

        // Backpressure after a MUL result
        req0_vld = 1'b1; req0_ctl = 16'h0800; req0_op1 = 32'd9; req0_op2 = 32'd11;
        #1;
        chk("bp_grant", {31'b0, req0_rdy}, 32'd1);
        tick();
        req0_vld = 1'b0;
        req1_vld = 1'b1; req1_ctl = 16'h0001; req1_op1 = 32'd4; req1_op2 = 32'd4;
        wait_rsp(20, cyc);
        chk("bp_latency", cyc, 3);
        for (int c = 0; c < 10; c++) begin
            chk("bp_vld_hold", {31'b0, rsp_vld}, 32'd1);
            chk("bp_res_hold", rsp_res, 32'd99);
            chk("bp_rdy_blocked", {30'b0, req1_rdy, req0_rdy}, 32'd0);
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("bp_vld_clear", {31'b0, rsp_vld}, 32'd0);
        chk("bp_idle_grant", {31'b0, req1_rdy}, 32'd1);
        req1_vld = 1'b0;
        tick();

        // Reset during EXEC of a MULH drops the operation
        req0_vld = 1'b1; req0_ctl = 16'h1000; req0_op1 = 32'h8000_0000; req0_op2 = 32'h0000_0004;
        req1_vld = 1'b0;
        #1;
        chk("mrst_grant", {31'b0, req0_rdy}, 32'd1);
        tick();
        req0_vld = 1'b0;
        chk("mrst_exec_ctl", {16'b0, alu_ctl}, 32'h0000_1000);
        rst_n = 1'b0;
        #1;
        chk("mrst_alu_ctl", {16'b0, alu_ctl}, 32'd0);
        chk("mrst_alu_op1", alu_op1, 32'd0);
        chk("mrst_alu_op2", alu_op2, 32'd0);
        chk("mrst_rsp", {rsp_res[29:0], rsp_vld, rsp_err}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("mrst_no_rsp", {31'b0, rsp_vld}, 32'd0);
            tick();
        end
        req0_vld = 1'b1; req0_ctl = 16'h0001; req0_op1 = 32'd1; req0_op2 = 32'd2;
        req1_vld = 1'b1; req1_ctl = 16'h0002; req1_op1 = 32'd9; req1_op2 = 32'd1;
        #1;
        chk("mrst_rr_req0", {30'b0, req1_rdy, req0_rdy}, 32'd1);
        tick();
        req0_vld = 1'b0; req1_vld = 1'b0;
        wait_rsp(20, cyc);
        chk("mrst_post_id", {31'b0, rsp_id}, 32'd0);
        chk("mrst_post_res", rsp_res, 32'd3);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
